// File: rtl/riscv_pkg.sv
// riscv_pkg: shared integer-register-file constants and types.
//   XLEN     - default data width of an architectural register
//   REG_AW   - default register address width
//   NREGS    - default number of architectural registers
//   ZERO_REG - hard-wired zero register index
//   reg_addr_t - register address type
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_sb_ctrl.sv
// regfile_sb_ctrl: per-register pending scoreboard with registered popcount.
//   clk, reset        - clock, synchronous active-high reset
//   sb_set, sb_addr   - mark a register pending (long-latency op issued)
//   we1, wa1          - long-latency writeback; clears the pending bit
//   pend              - current pending vector (bit 0 always 0)
//   pend_cnt          - number of pending registers, same edge as pend
module regfile_sb_ctrl
    import riscv_pkg::*;
#(
    parameter int  DEPTH = riscv_pkg::NREGS,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sb_set,
    input  logic [AW-1:0]    sb_addr,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    output logic [DEPTH-1:0] pend,
    output logic [AW:0]      pend_cnt
);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_nxt;
    logic [AW:0]      r_cnt;
    logic [AW:0]      w_cnt_nxt;

    // Set has priority over a same-cycle clear so an op issued in the same
    // cycle as an older writeback to that register is still tracked.
    always_comb begin
        w_pend_nxt = r_pend;
        w_cnt_nxt  = '0;
        for (int r = 1; r < DEPTH; r++) begin
            if (sb_set && int'(sb_addr) == r)
                w_pend_nxt[r] = 1'b1;
            else if (we1 && int'(wa1) == r)
                w_pend_nxt[r] = 1'b0;
        end
        w_pend_nxt[int'(ZERO_REG)] = 1'b0;
        // Count is taken from the next-state vector so it tracks pend exactly.
        for (int r = 0; r < DEPTH; r++)
            w_cnt_nxt = w_cnt_nxt + CW'(w_pend_nxt[r]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign pend     = r_pend;
    assign pend_cnt = r_cnt;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read, dual-write register file with pending scoreboard.
//   clk, reset          - clock, synchronous active-high reset
//   ra / rd / rbusy     - NREAD combinational read ports (packed, port k at k*W)
//   we0, wa0, wd0       - write port 0 (ALU writeback)
//   we1, wa1, wd1       - write port 1 (long-latency writeback, clears pending)
//   sb_set, sb_addr     - mark register pending
//   pend_cnt            - number of pending registers
// Register 0 reads 0, ignores writes and is never pending. With BYPASS=1 a
// same-cycle write is forwarded to reads (port 0 first) and a same-cycle
// port 1 write masks rbusy.
module regfile_mp_sb #(
    parameter int  XLEN   = riscv_pkg::XLEN,
    parameter int  DEPTH  = riscv_pkg::NREGS,
    parameter int  NREAD  = 2,
    parameter bit  BYPASS = 1'b1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [XLEN-1:0]       wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [XLEN-1:0]       wd1,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_addr,
    output logic [AW:0]           pend_cnt
);
    import riscv_pkg::*;

    localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0] w_pend;
    logic             w_we0;
    logic             w_we1;

    assign w_we0 = we0 && (wa0 != ZA);
    assign w_we1 = we1 && (wa1 != ZA);

    // On a same-address dual write, port 0 (the younger in-order result) wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_we0)
                r_mem[wa0] <= wd0;
            if (w_we1 && !(w_we0 && wa0 == wa1))
                r_mem[wa1] <= wd1;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit0;
        logic          w_hit1;

        assign w_ra   = ra[k*AW +: AW];
        assign w_hit0 = BYPASS && w_we0 && (wa0 == w_ra);
        assign w_hit1 = BYPASS && w_we1 && (wa1 == w_ra);

        assign rd[k*XLEN +: XLEN] = (w_ra == ZA) ? '0  :
                                    w_hit0       ? wd0 :
                                    w_hit1       ? wd1 : r_mem[w_ra];
        assign rbusy[k] = (w_ra != ZA) && w_pend[w_ra] && !w_hit1;
    end

    regfile_sb_ctrl #(.DEPTH(DEPTH)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .we1      (we1),
        .wa1      (wa1),
        .pend     (w_pend),
        .pend_cnt (pend_cnt)
    );

    // Dual write to one register usually means a pipeline hazard upstream.
    a_dual_write: assert property (@(posedge clk) disable iff (reset)
        !(w_we0 && w_we1 && wa0 == wa1))
        else $warning("dual write to reg %0d, port 0 data kept", wa0);
endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;
    localparam int AW = 5;
    localparam int XL = 32;
    localparam int NR = 2;
    localparam int D  = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [AW-1:0]    ra0, ra1, wa0, wa1, sb_addr;
    logic             we0, we1, sb_set;
    logic [XL-1:0]    wd0, wd1;
    logic [NR*AW-1:0] ra;
    logic [NR*XL-1:0] rd_b, rd_n;
    logic [NR-1:0]    rb_b, rb_n;
    logic [AW:0]      cnt_b, cnt_n;

    int vectors = 0;
    int misses  = 0;

    // Reference model: architectural state only.
    logic [XL-1:0] m_mem [D];
    bit            m_pend [D];

    assign ra = {ra1, ra0};

    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(XL), .DEPTH(D), .NREAD(NR), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_b), .rbusy(rb_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend_cnt(cnt_b));

    regfile_mp_sb #(.XLEN(XL), .DEPTH(D), .NREAD(NR), .BYPASS(1'b0)) u_nob (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd_n), .rbusy(rb_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .sb_set(sb_set), .sb_addr(sb_addr), .pend_cnt(cnt_n));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XL-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0)                      return '0;
        if (byp && we0 && wa0 == a)      return wd0;
        if (byp && we1 && wa1 == a)      return wd1;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        return m_pend[a] && !(byp && we1 && wa1 == a);
    endfunction

    function automatic int pend_total();
        int n = 0;
        for (int r = 0; r < D; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    task automatic check_all();
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            a = (k == 0) ? ra0 : ra1;
            chk($sformatf("rd_byp%0d", k),   rd_b[k*XL +: XL], exp_rd(a, 1'b1));
            chk($sformatf("rd_nob%0d", k),   rd_n[k*XL +: XL], exp_rd(a, 1'b0));
            chk($sformatf("busy_byp%0d", k), 32'(rb_b[k]),     32'(exp_busy(a, 1'b1)));
            chk($sformatf("busy_nob%0d", k), 32'(rb_n[k]),     32'(exp_busy(a, 1'b0)));
        end
        chk("cnt_byp", 32'(cnt_b), 32'(pend_total()));
        chk("cnt_nob", 32'(cnt_n), 32'(pend_total()));
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int r = 0; r < D; r++) begin
                m_mem[r]  = '0;
                m_pend[r] = 1'b0;
            end
        end else begin
            if (we1 && wa1 != 0 && !(we0 && wa0 == wa1)) m_mem[wa1] = wd1;
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_pend[wa1] = 1'b0;
            if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
        end
    endtask

    task automatic tick(input bit do_chk = 1'b1);
        if (do_chk) check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        reset = 1'b0; we0 = 1'b0; we1 = 1'b0; sb_set = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
    endfunction

    initial begin
        ra0 = '0; ra1 = '0; wa0 = '0; wa1 = '0; sb_addr = '0;
        wd0 = '0; wd1 = '0;
        for (int r = 0; r < D; r++) begin m_mem[r] = '0; m_pend[r] = 1'b0; end

        // 1. reset with a write asserted
        reset = 1'b1; we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD; we1 = 1'b0; sb_set = 1'b0;
        #1; tick(1'b0);
        #1; tick();
        quiet(); ra0 = 5'd5;
        #1; chk("t1_rd5", rd_b[31:0], 32'h0); chk("t1_cnt", 32'(cnt_b), 32'h0); tick();

        // 2. bypass vs stored value
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234; ra0 = 5'd3;
        #1; chk("t2_byp", rd_b[31:0], 32'h1234); chk("t2_nob_old", rd_n[31:0], 32'h0); tick();
        we0 = 1'b0;
        #1; chk("t2_nob_next", rd_n[31:0], 32'h1234); tick();

        // 3. set pending, then clear via port 1
        sb_set = 1'b1; sb_addr = 5'd7; ra1 = 5'd7;
        #1; tick();
        sb_set = 1'b0;
        #1; chk("t3_busy", 32'(rb_b[1]), 32'h1); chk("t3_cnt1", 32'(cnt_b), 32'h1); tick();
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hCAFE;
        #1; chk("t3_busy_byp", 32'(rb_b[1]), 32'h0); chk("t3_busy_nob", 32'(rb_n[1]), 32'h1);
        chk("t3_rd_byp", rd_b[63:32], 32'hCAFE); tick();
        we1 = 1'b0;
        #1; chk("t3_cnt0", 32'(cnt_b), 32'h0); chk("t3_rd_nob", rd_n[63:32], 32'hCAFE); tick();

        // 4. set wins over same-cycle clear
        sb_set = 1'b1; sb_addr = 5'd7;
        #1; tick();
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hBEEF;
        #1; tick();
        quiet();
        #1; chk("t4_cnt", 32'(cnt_b), 32'h1); chk("t4_busy", 32'(rb_n[1]), 32'h1);
        chk("t4_rd", rd_n[63:32], 32'hBEEF); tick();

        // 5. dual write to reg 9
        sb_set = 1'b1; sb_addr = 5'd9; ra0 = 5'd9;
        #1; tick();
        sb_set = 1'b0; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1; we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2;
        #1; chk("t5_byp", rd_b[31:0], 32'h1); tick();
        quiet();
        #1; chk("t5_rd", rd_n[31:0], 32'h1); chk("t5_busy", 32'(rb_n[0]), 32'h0);
        chk("t5_cnt", 32'(cnt_b), 32'h1); tick();

        // 6. register 0 immune; fill scoreboard
        reset = 1'b1;
        #1; tick();
        quiet(); sb_set = 1'b1; sb_addr = 5'd0; we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; ra0 = 5'd0;
        #1; chk("t6_rd0_byp", rd_b[31:0], 32'h0); tick();
        quiet();
        #1; chk("t6_rd0", rd_n[31:0], 32'h0); chk("t6_cnt0", 32'(cnt_b), 32'h0); tick();
        for (int r = 1; r < D; r++) begin
            sb_set = 1'b1; sb_addr = AW'(r);
            #1; tick();
        end
        sb_set = 1'b0;
        #1; chk("t6_full_byp", 32'(cnt_b), 32'd31); chk("t6_full_nob", 32'(cnt_n), 32'd31); tick();
        sb_set = 1'b1; sb_addr = 5'd4;
        #1; tick();
        sb_set = 1'b0;
        #1; chk("t6_reset_again", 32'(cnt_b), 32'd31); tick();

        // mid-operation reset, then a late port 1 write
        reset = 1'b1; we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h55;
        #1; tick();
        reset = 1'b0; we1 = 1'b0;
        #1; chk("rst_cnt", 32'(cnt_b), 32'h0); tick();
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h77; ra0 = 5'd4;
        #1; tick();
        we1 = 1'b0;
        #1; chk("late_rd", rd_n[31:0], 32'h77); chk("late_cnt", 32'(cnt_n), 32'h0); tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom % 60) == 0;
            we0     = $urandom % 2;  wa0 = rand_addr(); wd0 = $urandom;
            we1     = $urandom % 2;  wa1 = rand_addr(); wd1 = $urandom;
            sb_set  = ($urandom % 3) == 0; sb_addr = rand_addr();
            ra0     = rand_addr(); ra1 = rand_addr();
            if (we0 && we1 && wa0 == wa1) we1 = 1'b0;
            #1; tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
